timer_array: RTL

TIMER_ARRAY -- requirements
Module: timer_array

---
 rtl/timer_pkg.sv | 16 +
 rtl/timer_prescaler.sv | 36 +++
 rtl/timer_array.sv | 122 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and default sizes for the timer array.
// Contents:
//   ch_state_e            per-channel state (StIdle / StRun)
//   DEF_N_CH/CNT_W/PRE_W  default channel count and widths
package timer_pkg;

  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_PRE_W = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Shared prescaler. Produces a one-clk clock-enable strobe every prescaler+1 clocks
// while i_pre_en is high. It never generates a clock.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   i_pre_en      run enable; low clears the counter and suppresses the strobe
//   i_prescaler   divide value; strobe period = i_prescaler+1 clk
//   o_strobe      clock enable for the timer channels
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pre_en,
  input  logic [PRE_W-1:0] i_prescaler,
  output logic             o_strobe
);

  logic [PRE_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit    = (r_cnt == i_prescaler);
  assign o_strobe = i_pre_en && w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_pre_en || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/timer_array.sv
// Array of N_CH independent up/down timers sharing one prescaler strobe.
// Each channel is IDLE or RUN; in RUN it counts on every strobe while en is high and
// raises a registered one-clk tick at terminal count, then reloads (periodic) or
// returns to IDLE with count 0 (one-shot).
// Configuration macro: TIMER_ARRAY_PWM_EN enables per-channel registered PWM
// (pwm = running && count < cmp); when undefined pwm is tied low and cmp is ignored.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   pre_en, prescaler   shared prescaler enable and divide value
//   en/start/stop       per-channel count enable, start pulse, stop pulse
//   up_down, one_shot   per-channel direction (1=up) and mode (1=one-shot)
//   load, cmp           packed per-channel reload and PWM compare values
//   tick, running       per-channel terminal pulse and RUN indicator
//   count, pwm          packed per-channel counts and PWM outputs
module timer_array
  import timer_pkg::*;
#(
  parameter int unsigned N_CH  = DEF_N_CH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned PRE_W = DEF_PRE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pre_en,
  input  logic [PRE_W-1:0]      prescaler,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       up_down,
  input  logic [N_CH-1:0]       one_shot,
  input  logic [N_CH*CNT_W-1:0] load,
  input  logic [N_CH*CNT_W-1:0] cmp,
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       running,
  output logic [N_CH*CNT_W-1:0] count,
  output logic [N_CH-1:0]       pwm
);

  logic w_strobe;

  timer_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_pre_en   (pre_en),
    .i_prescaler(prescaler),
    .o_strobe   (w_strobe)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_e        r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_tick;
    logic [CNT_W-1:0] w_load;
    logic             w_term;

    assign w_load = load[g*CNT_W +: CNT_W];
    // Terminal compare uses the live load/direction so changes apply at the next strobe.
    assign w_term = up_down[g] ? (r_count == w_load) : (r_count == '0);

    // Priority: stop > start > strobe counting.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= StIdle;
        r_count <= '0;
        r_tick  <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (stop[g]) begin
          r_state <= StIdle;
        end else if (start[g]) begin
          r_state <= StRun;
          r_count <= up_down[g] ? '0 : w_load;
        end else if ((r_state == StRun) && en[g] && w_strobe) begin
          if (w_term) begin
            r_tick <= 1'b1;
            if (one_shot[g]) begin
              r_state <= StIdle;
              r_count <= '0;
            end else begin
              r_count <= up_down[g] ? '0 : w_load;
            end
          end else if (up_down[g]) begin
            r_count <= r_count + CNT_W'(1);
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
      end
    end

    assign tick[g]                  = r_tick;
    assign running[g]               = (r_state == StRun);
    assign count[g*CNT_W +: CNT_W]  = r_count;

`ifdef TIMER_ARRAY_PWM_EN
    logic             r_pwm;
    logic [CNT_W-1:0] w_cmp;

    assign w_cmp = cmp[g*CNT_W +: CNT_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pwm <= 1'b0;
      end else begin
        r_pwm <= (r_state == StRun) && (r_count < w_cmp);
      end
    end

    assign pwm[g] = r_pwm;
`else
    assign pwm[g] = 1'b0;
`endif
  end

`ifndef TIMER_ARRAY_PWM_EN
  logic w_unused_cmp;
  assign w_unused_cmp = ^cmp;
`endif

endmodule
